// File: rtl/nnet_out_framer_if.sv
// rtl/nnet_out_framer_if.sv - stream bundle between the HLS core, the framer and the AXI wrapper
//
// Purpose: groups the framer's input result stream (s_*) and its framed output
// stream (m_*) so they travel as one port.
// Signals:
//   s_tdata  [DATA_W] raw HLS result, two's complement
//   s_tvalid           result valid
//   s_tready           framer can accept a result
//   m_tdata  [OUT_W]   framed sample
//   m_tlast            last sample of packet
//   m_tvalid           framed sample valid
//   m_tready           downstream accepts framed sample
// Modports:
//   slave  - the framer (sinks s_*, sources m_*)
//   master - the environment around it (sources s_*, sinks m_*)
interface nnet_out_framer_if #(
   parameter int DATA_W = 18,
   parameter int OUT_W  = 32
);
   logic [DATA_W-1:0] s_tdata;
   logic              s_tvalid;
   logic              s_tready;
   logic [OUT_W-1:0]  m_tdata;
   logic              m_tlast;
   logic              m_tvalid;
   logic              m_tready;

   modport slave (
      input  s_tdata, s_tvalid, m_tready,
      output s_tready, m_tdata, m_tlast, m_tvalid
   );

   modport master (
      output s_tdata, s_tvalid, m_tready,
      input  s_tready, m_tdata, m_tlast, m_tvalid
   );
endinterface

// File: rtl/nnet_out_framer.sv
// rtl/nnet_out_framer.sv - frames raw HLS results into 32-bit packets with tlast
//
// Purpose: counts results against the output vector size, closes a packet every
// spp samples and at every vector end, and sign-extends each result to OUT_W.
// Output register plus one skid register; s_tready is registered.
// Optional macro: NNET_FRAMER_SAT16_EN - clamp each result to signed 16 bits
// before sign extension (no added latency).
// Ports:
//   ap_clk     clock
//   ap_rst_n   synchronous active-low reset
//   clear      synchronous flush, like reset but keeps vec_count
//   size_out   samples per output vector (0 treated as 1)
//   spp        samples per packet, 0 = tlast only at vector end
//   bus        stream bundle (slave side): s_* results in, m_* framed samples out
//   vec_count  completed vectors, wraps at 2^32
//   busy       vector in progress
module nnet_out_framer #(
   parameter int DATA_W = 18,
   parameter int OUT_W  = 32,
   parameter int CNT_W  = 16
) (
   input  logic             ap_clk,
   input  logic             ap_rst_n,
   input  logic             clear,
   input  logic [CNT_W-1:0] size_out,
   input  logic [CNT_W-1:0] spp,
   nnet_out_framer_if.slave bus,
   output logic [31:0]      vec_count,
   output logic             busy
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state, state_n;
   logic [CNT_W-1:0]  samp_idx, samp_idx_n;
   logic [CNT_W-1:0]  pkt_idx, pkt_idx_n;
   logic [CNT_W-1:0]  size_l, spp_l;
   logic [CNT_W-1:0]  size_cur, spp_cur;
   logic              accept, vec_end, pkt_end, last_in;
   logic              flush;

   logic signed [DATA_W-1:0] in_s;
   logic [OUT_W-1:0]         in_ext;

   logic              load_out;
   logic              skid_valid, skid_valid_n;
   logic [OUT_W-1:0]  skid_data;
   logic              skid_last;

   assign flush = !ap_rst_n || clear;
   assign busy  = (state == RUN);

   // In IDLE the live size/spp apply to the sample being accepted (it opens the
   // vector); in RUN the values latched at vector start are used.
   always_comb begin
      accept     = bus.s_tvalid && bus.s_tready;
      size_cur   = size_l;
      spp_cur    = spp_l;
      if (state == IDLE) begin
         size_cur = (size_out == '0) ? CNT_W'(1) : size_out;
         spp_cur  = spp;
      end
      vec_end    = (samp_idx == size_cur - CNT_W'(1));
      pkt_end    = (spp_cur != '0) && (pkt_idx == spp_cur - CNT_W'(1));
      last_in    = vec_end || pkt_end;
      state_n    = state;
      samp_idx_n = samp_idx;
      pkt_idx_n  = pkt_idx;
      if (accept) begin
         if (vec_end) begin
            state_n    = IDLE;
            samp_idx_n = '0;
            pkt_idx_n  = '0;
         end else begin
            state_n    = RUN;
            samp_idx_n = samp_idx + CNT_W'(1);
            pkt_idx_n  = pkt_end ? '0 : pkt_idx + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge ap_clk) begin
      if (flush) begin
         state    <= IDLE;
         samp_idx <= '0;
         pkt_idx  <= '0;
         size_l   <= CNT_W'(1);
         spp_l    <= '0;
      end else begin
         state    <= state_n;
         samp_idx <= samp_idx_n;
         pkt_idx  <= pkt_idx_n;
         if (state == IDLE && accept) begin
            size_l <= size_cur;
            spp_l  <= spp_cur;
         end
      end
   end

   // clear must not count a vector end accepted in the same cycle it is flushed
   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         vec_count <= '0;
      end else if (!clear && accept && vec_end) begin
         vec_count <= vec_count + 32'd1;
      end
   end

   // Result conversion; a signed-to-wider cast sign-extends
   localparam logic signed [DATA_W-1:0] SAT_MAX = DATA_W'(32767);
   localparam logic signed [DATA_W-1:0] SAT_MIN = ~SAT_MAX;

   always_comb begin
      in_s = bus.s_tdata;
`ifdef NNET_FRAMER_SAT16_EN
      if (in_s > SAT_MAX) begin
         in_s = SAT_MAX;
      end else if (in_s < SAT_MIN) begin
         in_s = SAT_MIN;
      end
`endif
      in_ext = OUT_W'(in_s);
   end

   // Output register can take new content when empty or being popped
   always_comb begin
      load_out     = !bus.m_tvalid || bus.m_tready;
      skid_valid_n = load_out ? (skid_valid && accept) : (skid_valid || accept);
   end

   always_ff @(posedge ap_clk) begin
      if (flush) begin
         bus.m_tvalid <= 1'b0;
         bus.m_tlast  <= 1'b0;
         bus.m_tdata  <= '0;
         bus.s_tready <= 1'b0;
         skid_valid   <= 1'b0;
         skid_data    <= '0;
         skid_last    <= 1'b0;
      end else begin
         if (load_out) begin
            if (skid_valid) begin
               // older sample waiting in skid goes first
               bus.m_tdata  <= skid_data;
               bus.m_tlast  <= skid_last;
               bus.m_tvalid <= 1'b1;
               if (accept) begin
                  skid_data <= in_ext;
                  skid_last <= last_in;
               end
            end else begin
               bus.m_tvalid <= accept;
               if (accept) begin
                  bus.m_tdata <= in_ext;
                  bus.m_tlast <= last_in;
               end
            end
         end else if (accept) begin
            skid_data <= in_ext;
            skid_last <= last_in;
         end
         skid_valid   <= skid_valid_n;
         bus.s_tready <= !skid_valid_n;
      end
   end

endmodule

// File: tb/tb_nnet_out_framer.sv
// tb/tb_nnet_out_framer.sv - randomized self-checking bench for nnet_out_framer
module tb_nnet_out_framer;

   logic        ap_clk = 1'b0;
   logic        ap_rst_n;
   logic        clear;
   logic [15:0] size_out;
   logic [15:0] spp;
   logic [31:0] vec_count;
   logic        busy;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   logic [32:0] exp_q[$];
   logic [32:0] got_q[$];

   // reference model state: position inside the current vector
   int          m_pos = 0;
   int          m_size = 1;
   int          m_spp = 0;
   logic [31:0] m_vec = 0;

   bit          rand_ready = 0;
   int          stab_err = 0;
   bit          hold_prev = 0;
   logic [31:0] prev_d;
   logic        prev_l;

   nnet_out_framer_if #(.DATA_W(18), .OUT_W(32)) bus ();

   nnet_out_framer #(.DATA_W(18), .OUT_W(32), .CNT_W(16)) dut (
      .ap_clk    (ap_clk),
      .ap_rst_n  (ap_rst_n),
      .clear     (clear),
      .size_out  (size_out),
      .spp       (spp),
      .bus       (bus),
      .vec_count (vec_count),
      .busy      (busy)
   );

   always #5 ap_clk = ~ap_clk;

   always @(posedge ap_clk) begin
      cyc++;
      #1;
      bus.m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   function automatic logic [31:0] model_data(input logic [17:0] d);
      int v;
      v = $signed(d);
`ifdef NNET_FRAMER_SAT16_EN
      if (v > 32767) v = 32767;
      else if (v < -32768) v = -32768;
`endif
      return 32'(v);
   endfunction

   // Observes both handshakes half a cycle before the edge that completes them
   always @(negedge ap_clk) begin
      bit lst;
      if (!ap_rst_n || clear) begin
         m_pos = 0;
         if (!ap_rst_n) m_vec = 0;
         hold_prev = 0;
      end else begin
         if (hold_prev && (bus.m_tvalid !== 1'b1 || bus.m_tdata !== prev_d || bus.m_tlast !== prev_l))
            stab_err++;
         hold_prev = bus.m_tvalid && !bus.m_tready;
         prev_d = bus.m_tdata;
         prev_l = bus.m_tlast;
         if (bus.m_tvalid && bus.m_tready)
            got_q.push_back({bus.m_tdata, bus.m_tlast});
         if (bus.s_tvalid && bus.s_tready) begin
            if (m_pos == 0) begin
               m_size = (size_out == 0) ? 1 : int'(size_out);
               m_spp  = int'(spp);
            end
            lst = (m_pos == m_size - 1) || (m_spp != 0 && (m_pos % m_spp) == m_spp - 1);
            exp_q.push_back({model_data(bus.s_tdata), lst});
            if (m_pos == m_size - 1) begin
               m_pos = 0;
               m_vec++;
            end else begin
               m_pos++;
            end
         end
      end
   end

   task automatic send_sample(input logic [17:0] d);
      int  n;
      bit  acc;
      n = 0;
      acc = 0;
      bus.s_tdata  = d;
      bus.s_tvalid = 1'b1;
      while (!acc && n < 100) begin
         @(negedge ap_clk);
         acc = bus.s_tready;
         @(posedge ap_clk);
         #1;
         n++;
      end
      bus.s_tvalid = 1'b0;
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL send_timeout data=%h not accepted in 100 cycles", d);
      end
   endtask

   task automatic drain(output bit ok);
      int n;
      n = 0;
      while (got_q.size() < exp_q.size() && n < 200) begin
         @(posedge ap_clk);
         #1;
         n++;
      end
      ok = (got_q.size() == exp_q.size());
   endtask

   task automatic test_reset();
      ap_rst_n = 1'b0;
      clear = 1'b0;
      size_out = 16'd1;
      spp = 16'd0;
      bus.s_tvalid = 1'b0;
      bus.s_tdata = '0;
      repeat (3) @(posedge ap_clk);
      #1;
      checks++;
      if (bus.m_tvalid !== 1'b0 || bus.m_tlast !== 1'b0 || bus.m_tdata !== 32'd0) begin
         errors++;
         $display("FAIL reset_out got v=%b l=%b d=%h exp 0 0 0", bus.m_tvalid, bus.m_tlast, bus.m_tdata);
      end
      checks++;
      if (bus.s_tready !== 1'b0 || busy !== 1'b0 || vec_count !== 32'd0) begin
         errors++;
         $display("FAIL reset_ctl got rdy=%b busy=%b vc=%0d exp 0 0 0", bus.s_tready, busy, vec_count);
      end
      ap_rst_n = 1'b1;
      @(posedge ap_clk);
      #1;
      checks++;
      if (bus.s_tready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready got %b exp 1", bus.s_tready);
      end
   endtask

   task automatic test_frame();
      bit ok;
      int c0;
      exp_q.delete();
      got_q.delete();
      size_out = 16'd10;
      spp = 16'd4;
      c0 = cyc;
      send_sample(18'd0);
      checks++;
      if (bus.m_tvalid !== 1'b1 || bus.m_tdata !== 32'd0 || bus.m_tlast !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL frame_latency got v=%b d=%h l=%b busy=%b exp 1 0 0 1", bus.m_tvalid, bus.m_tdata, bus.m_tlast, busy);
      end
      for (int i = 1; i < 10; i++) send_sample(18'(i));
      checks++;
      if (cyc - c0 !== 10) begin
         errors++;
         $display("FAIL frame_rate got %0d cycles exp 10", cyc - c0);
      end
      checks++;
      if (bus.m_tdata !== 32'd9 || bus.m_tlast !== 1'b1 || busy !== 1'b0 || vec_count !== 32'd1) begin
         errors++;
         $display("FAIL frame_end got d=%h l=%b busy=%b vc=%0d exp 9 1 0 1", bus.m_tdata, bus.m_tlast, busy, vec_count);
      end
      drain(ok);
      checks++;
      if (!ok || got_q.size() !== 10) begin
         errors++;
         $display("FAIL frame_count got=%0d exp=10", got_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i] || got_q[i][0] !== (i == 3 || i == 7 || i == 9)) begin
            errors++;
            $display("FAIL frame_item[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_sign();
      bit ok;
      logic [31:0] want[3];
`ifdef NNET_FRAMER_SAT16_EN
      want = '{32'hFFFFFFFF, 32'hFFFF8000, 32'h00007FFF};
`else
      want = '{32'hFFFFFFFF, 32'hFFFE0000, 32'h0001FFFF};
`endif
      exp_q.delete();
      got_q.delete();
      size_out = 16'd3;
      spp = 16'd0;
      send_sample(18'h3FFFF);
      send_sample(18'h20000);
      send_sample(18'h1FFFF);
      drain(ok);
      checks++;
      if (!ok || got_q.size() !== 3) begin
         errors++;
         $display("FAIL sign_count got=%0d exp=3", got_q.size());
      end
      for (int i = 0; i < got_q.size() && i < 3; i++) begin
         checks++;
         if (got_q[i][32:1] !== want[i] || got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL sign_item[%0d] got=%h exp=%h", i, got_q[i][32:1], want[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      logic [31:0] vc0;
      exp_q.delete();
      got_q.delete();
      stab_err = 0;
      vc0 = vec_count;
      size_out = 16'd7;
      spp = 16'd0;
      rand_ready = 1;
      for (int i = 0; i < 21; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(posedge ap_clk);
            #1;
         end
         send_sample(18'($urandom));
      end
      drain(ok);
      rand_ready = 0;
      checks++;
      if (!ok || got_q.size() !== 21) begin
         errors++;
         $display("FAIL bp_count got=%0d exp=21", got_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i] || got_q[i][0] !== ((i % 7) == 6)) begin
            errors++;
            $display("FAIL bp_item[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
         end
      end
      checks++;
      if (stab_err !== 0) begin
         errors++;
         $display("FAIL bp_stable got %0d changes under stall exp 0", stab_err);
      end
      checks++;
      if (vec_count !== vc0 + 32'd3) begin
         errors++;
         $display("FAIL bp_veccount got=%0d exp=%0d", vec_count, vc0 + 32'd3);
      end
   endtask

   task automatic test_size_change();
      bit ok;
      logic [31:0] vc0;
      exp_q.delete();
      got_q.delete();
      vc0 = vec_count;
      size_out = 16'd10;
      spp = 16'd3;
      for (int i = 0; i < 15; i++) begin
         if (i == 3) size_out = 16'd5;
         send_sample(18'($urandom));
      end
      drain(ok);
      checks++;
      if (!ok || got_q.size() !== 15) begin
         errors++;
         $display("FAIL size_count got=%0d exp=15", got_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i] ||
             got_q[i][0] !== (i == 2 || i == 5 || i == 8 || i == 9 || i == 12 || i == 14)) begin
            errors++;
            $display("FAIL size_item[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
         end
      end
      checks++;
      if (vec_count !== vc0 + 32'd2 || vec_count !== m_vec) begin
         errors++;
         $display("FAIL size_veccount got=%0d exp=%0d", vec_count, vc0 + 32'd2);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      size_out = 16'd10;
      spp = 16'd0;
      for (int i = 0; i < 4; i++) send_sample(18'($urandom));
      ap_rst_n = 1'b0;
      @(posedge ap_clk);
      #1;
      checks++;
      if (bus.m_tvalid !== 1'b0 || bus.m_tlast !== 1'b0 || bus.m_tdata !== 32'd0 ||
          bus.s_tready !== 1'b0 || vec_count !== 32'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_out got v=%b l=%b d=%h rdy=%b vc=%0d busy=%b exp all 0",
                  bus.m_tvalid, bus.m_tlast, bus.m_tdata, bus.s_tready, vec_count, busy);
      end
      ap_rst_n = 1'b1;
      exp_q.delete();
      got_q.delete();
      for (int i = 0; i < 10; i++) send_sample(18'($urandom));
      drain(ok);
      checks++;
      if (!ok || got_q.size() !== 10) begin
         errors++;
         $display("FAIL rstmid_count got=%0d exp=10", got_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i] || got_q[i][0] !== (i == 9)) begin
            errors++;
            $display("FAIL rstmid_item[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
         end
      end
      checks++;
      if (vec_count !== 32'd1) begin
         errors++;
         $display("FAIL rstmid_veccount got=%0d exp=1", vec_count);
      end
   endtask

   task automatic test_clear();
      bit ok;
      size_out = 16'd10;
      spp = 16'd4;
      for (int i = 0; i < 16; i++) send_sample(18'($urandom));
      clear = 1'b1;
      @(posedge ap_clk);
      #1;
      checks++;
      if (vec_count !== 32'd2 || bus.m_tvalid !== 1'b0 || bus.s_tready !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL clear_state got vc=%0d v=%b rdy=%b busy=%b exp 2 0 0 0",
                  vec_count, bus.m_tvalid, bus.s_tready, busy);
      end
      clear = 1'b0;
      exp_q.delete();
      got_q.delete();
      size_out = 16'd1;
      spp = 16'd0;
      for (int i = 0; i < 4; i++) send_sample(18'($urandom));
      drain(ok);
      checks++;
      if (!ok || got_q.size() !== 4) begin
         errors++;
         $display("FAIL clear_count got=%0d exp=4", got_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i] || got_q[i][0] !== 1'b1) begin
            errors++;
            $display("FAIL clear_item[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
         end
      end
      checks++;
      if (vec_count !== 32'd6) begin
         errors++;
         $display("FAIL clear_veccount got=%0d exp=6", vec_count);
      end
   endtask

   initial begin
      bus.s_tvalid = 1'b0;
      bus.s_tdata  = '0;
      test_reset();
      test_frame();
      test_sign();
      test_backpressure();
      test_size_change();
      test_reset_mid();
      test_clear();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/nnet_out_framer.md
# nnet_out_framer

Downstream stage of the HLS neural-net core: consumes the core's raw 18-bit result stream (no tlast) and produces 32-bit AXI-stream samples with tlast, ready for the AXI wrapper's packet input. It counts results against the net's output vector size, closes a packet every `spp` samples and at every vector end, and sign-extends (or saturates) each result. Full throughput, registered outputs, skid-buffered input.

## Interface
Parameters:
- `DATA_W`, 18, width of HLS result word (two's complement).
- `OUT_W`, 32, output word width; must be ≥ `DATA_W`.
- `CNT_W`, 16, width of size/spp counters.

Ports:
- `ap_clk`  in  1  clock; sole clock.
- `ap_rst_n`  in  1  reset; synchronous, active-low.
- `clear`  in  1  synchronous flush, same effect as reset except `vec_count` is kept.
- `size_out`  in  CNT_W  samples per output vector (from HLS const port).
- `spp`  in  CNT_W  samples per packet; 0 = tlast only at vector end.
- `s_tdata`  in  DATA_W  result from HLS core.
- `s_tvalid`  in  1  result valid.
- `s_tready`  out  1  accept; registered.
- `m_tdata`  out  OUT_W  framed sample.
- `m_tlast`  out  1  last sample of packet.
- `m_tvalid`  out  1  output valid.
- `m_tready`  in  1  downstream accept.
- `vec_count`  out  32  completed vectors, wraps at 2^32.
- `busy`  out  1  vector in progress (state RUN).

## Operation
- States: IDLE, RUN. IDLE→RUN on first accepted sample; RUN→IDLE when the sample with `samp_idx == size_l-1` is accepted.
- On the IDLE→RUN transfer, latch `size_l = max(size_out,1)` and `spp_l = spp`; changes to `size_out`/`spp` in RUN are ignored until next vector.
- Counters: `samp_idx` (0..size_l-1), `pkt_idx` (0..spp_l-1); both advance per accepted input. `pkt_idx` resets to 0 after tlast and at vector end.
- tlast = (`samp_idx == size_l-1`) OR (`spp_l != 0` AND `pkt_idx == spp_l-1`). Short final packet allowed when `size_l` not a multiple of `spp_l`.
- Data: `m_tdata` = `s_tdata` sign-extended to `OUT_W`.
- `vec_count` increments when the vector-end sample is accepted at input.
- Buffer: output register plus one skid register; never drops or duplicates; order preserved.

## Timing
- Reset (`ap_rst_n`=0 at edge) or `clear`: `m_tvalid`=0, `m_tlast`=0, `m_tdata`=0, `s_tready`=0 for that cycle then 1 next cycle, state IDLE, counters 0, skid empty; `busy`=0. Reset also zeroes `vec_count`.
- Reset/clear mid-vector abandons the partial vector; no tlast emitted for it; next accepted sample starts a fresh vector.
- Latency: input accepted at cycle N appears on `m_*` at cycle N+1 when output empty.
- `s_tready` = skid register empty (registered). With `m_tready` held 1: one sample per cycle sustained.
- `m_tready` deasserted with output full: next input lands in skid, `s_tready` drops following cycle; `m_tdata/m_tlast` stable while `m_tvalid && !m_tready`.
- Simultaneous output pop and input push: skid content (if any) moves to output, new input into skid; no bubble.
- `size_out`=1: every sample has tlast; `vec_count` increments per sample.
- `busy` asserts cycle after first accept, deasserts cycle after vector-end accept.

## Configuration
- `NNET_FRAMER_SAT16_EN` defined: each result saturated to signed 16-bit (clamp to +32767 / −32768) then sign-extended to `OUT_W`; adds no latency.
- Not defined: plain sign extension of the full `DATA_W` value.

## Test plan
- size_out=10, spp=4, ramp 0..9, m_tready=1 -> tlast on samples 3,7,9; `vec_count`=1; one sample/cycle, latency 1.
- s_tdata=18'h3FFFF and 18'h20000 -> m_tdata 32'hFFFFFFFF and 32'hFFFE0000; with `NNET_FRAMER_SAT16_EN`: 18'h1FFFF -> 32'h00007FFF, 18'h20000 -> 32'hFFFF8000.
- Random m_tready (50%), 3 vectors size_out=7, spp=0 -> 21 samples in order, tlast on 7th/14th/21st only, data stable under backpressure.
- size_out changed 10->5 at sample 3 of vector -> current vector still 10 samples, next vector 5.
- ap_rst_n low for 1 cycle at sample 4 of 10 -> all outputs 0 next cycle, `vec_count`=0; next 10 samples framed as a fresh vector.
- `clear` at sample 6 with `vec_count`=2 -> partial vector dropped, `vec_count` stays 2, size_out=1 then gives tlast every sample.
